snn_row_conv_pe: RTL and testbench

- Clocked, parametrised spiking-convolution processing element for the NoC-based SNN accelerator.
- Accepts kernel-row and ifmap-row packets from the router and computes a 1-D valid convolution of one binary spike row against one K-tap weight row, one MAC per cycle.
- Emits one partial-sum packet per output column to that column's adder node.
- Optionally forwards ifmap rows to a neighbour PE for row reuse within a timestep.

---
 rtl/snn_row_conv_pe_if.sv | 12 +
 rtl/snn_row_conv_pe.sv | 163 ++++++++++++++++
 tb/tb_snn_row_conv_pe.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/snn_row_conv_pe_if.sv
// Valid/ready packet channel between a PE and the NoC router.
// The master drives valid and pkt, and the slave returns ready.
interface snn_row_conv_pe_if #(
    parameter int unsigned PKT_W = 34
) ();
    logic             valid;
    logic             ready;
    logic [PKT_W-1:0] pkt;

    modport master (output valid, output pkt, input ready);
    modport slave  (input valid, input pkt, output ready);
endinterface

// File: rtl/snn_row_conv_pe.sv
// Spiking row-convolution PE: binary ifmap row against one K-tap weight row, one MAC per cycle,
// one saturating partial-sum packet per output column, optional ifmap forwarding to a neighbour.
module snn_row_conv_pe #(
    parameter int unsigned       ADDR_W        = 4,
    parameter int unsigned       K             = 3,
    parameter int unsigned       WGT_W         = 8,
    parameter int unsigned       IFMAP_W       = 5,
    parameter int unsigned       PSUM_W        = 8,
    parameter int unsigned       PKT_W         = 34,
    parameter logic [ADDR_W-1:0] MY_ADDR       = 4'b0110,
    parameter logic [ADDR_W-1:0] ADDER_BASE    = 4'b0001,
    parameter int unsigned       ADDER_STRIDE  = 4,
    parameter logic [ADDR_W-1:0] NEIGHBOR_ADDR = 4'b0010,
    parameter bit                FWD_EN        = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    snn_row_conv_pe_if.slave    in_if,
    snn_row_conv_pe_if.master   out_if,
    output logic                pkt_drop,
    output logic                busy
);
    localparam int unsigned OUT_W = IFMAP_W - K + 1;
    localparam int unsigned PAY_W = PKT_W - 2*ADDR_W - 2;
    localparam int unsigned MAX_A = (K*WGT_W > IFMAP_W) ? K*WGT_W : IFMAP_W;
    localparam int unsigned MAX_W = (MAX_A > PSUM_W) ? MAX_A : PSUM_W;
    localparam int unsigned JW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int unsigned IW    = (K > 1) ? $clog2(K) : 1;
    localparam int unsigned XW    = (IFMAP_W > 1) ? $clog2(IFMAP_W) : 1;
    localparam int unsigned SUM_W = ((PSUM_W > WGT_W) ? PSUM_W : WGT_W) + 1;

    localparam logic [JW-1:0] J_LAST = JW'(OUT_W - 1);
    localparam logic [IW-1:0] I_LAST = IW'(K - 1);

    if (PAY_W < MAX_W) begin : g_pay_chk
        $error("snn_row_conv_pe: payload too narrow for kernel, ifmap or psum");
    end

    typedef enum logic [2:0] {IDLE, COMPUTE, EMIT, FWD, DONE} state_t;
    typedef enum logic [1:0] {PKT_IFMAP, PKT_KERNEL, PKT_PSUM, PKT_RSVD} pkt_type_t;

    state_t                 state;
    logic [WGT_W-1:0]       w [K];
    logic [IFMAP_W-1:0]     spikes;
    logic [PSUM_W-1:0]      acc;
    logic [JW-1:0]          j;
    logic [IW-1:0]          i;
    logic [IW-1:0]          row_cnt;
    logic                   in_ready_q;
    logic                   out_valid_q;
    logic [PKT_W-1:0]       out_pkt_q;

    logic [ADDR_W-1:0]      in_dst;
    logic [1:0]             in_type;
    logic [PAY_W-1:0]       in_pay;
    logic                   unused_src;
    logic [XW-1:0]          idx;
    logic [WGT_W-1:0]       tap;
    logic [SUM_W-1:0]       sum;
    logic [PSUM_W-1:0]      sum_sat;
    logic [ADDR_W-1:0]      col_dst;
    logic [PKT_W-1:0]       psum_pkt;
    logic [PKT_W-1:0]       fwd_pkt;

    assign in_dst     = in_if.pkt[PKT_W-ADDR_W-1 -: ADDR_W];
    assign in_type    = in_if.pkt[PAY_W+1 -: 2];
    assign in_pay     = in_if.pkt[PAY_W-1:0];
    assign unused_src = ^in_if.pkt[PKT_W-1 -: ADDR_W];

    assign in_if.ready  = in_ready_q;
    assign out_if.valid = out_valid_q;
    assign out_if.pkt   = out_pkt_q;
    assign busy         = (state != IDLE);

    always_comb begin
        idx      = XW'(j) + XW'(i);
        tap      = spikes[idx] ? w[i] : '0;
        sum      = SUM_W'(acc) + SUM_W'(tap);
        // Any carry above PSUM_W bits clamps to all-ones instead of wrapping.
        sum_sat  = (sum[SUM_W-1:PSUM_W] != '0) ? '1 : sum[PSUM_W-1:0];
        col_dst  = ADDER_BASE + ADDR_W'(32'(j) * ADDER_STRIDE);
        psum_pkt = {MY_ADDR, col_dst, PKT_PSUM, PAY_W'(sum_sat)};
        fwd_pkt  = {MY_ADDR, NEIGHBOR_ADDR, PKT_IFMAP, PAY_W'(spikes)};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            w           <= '{default: '0};
            spikes      <= '0;
            acc         <= '0;
            j           <= '0;
            i           <= '0;
            row_cnt     <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_pkt_q   <= '0;
            pkt_drop    <= 1'b0;
        end else begin
            pkt_drop <= 1'b0;
            case (state)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (in_ready_q && in_if.valid) begin
                        if (in_dst != MY_ADDR || in_type[1]) begin
                            pkt_drop <= 1'b1;
                        end else if (in_type == PKT_KERNEL) begin
                            for (int unsigned t = 0; t < K; t++) begin
                                w[t] <= in_pay[t*WGT_W +: WGT_W];
                            end
                        end else begin
                            spikes     <= in_pay[IFMAP_W-1:0];
                            acc        <= '0;
                            j          <= '0;
                            i          <= '0;
                            in_ready_q <= 1'b0;
                            state      <= COMPUTE;
                        end
                    end
                end
                COMPUTE: begin
                    acc <= sum_sat;
                    if (i == I_LAST) begin
                        out_valid_q <= 1'b1;
                        out_pkt_q   <= psum_pkt;
                        state       <= EMIT;
                    end else begin
                        i <= i + 1'b1;
                    end
                end
                EMIT: begin
                    if (out_if.ready) begin
                        out_valid_q <= 1'b0;
                        if (j < J_LAST) begin
                            j     <= j + 1'b1;
                            i     <= '0;
                            acc   <= '0;
                            state <= COMPUTE;
                        end else if (FWD_EN && row_cnt < I_LAST) begin
                            out_valid_q <= 1'b1;
                            out_pkt_q   <= fwd_pkt;
                            state       <= FWD;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                FWD: begin
                    if (out_if.ready) begin
                        out_valid_q <= 1'b0;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    row_cnt    <= (row_cnt == I_LAST) ? '0 : row_cnt + 1'b1;
                    in_ready_q <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_snn_row_conv_pe.sv
// Scoreboard bench for snn_row_conv_pe: expected packets are queued when rows are sent
// and popped by a monitor as output transfers occur.
module tb_snn_row_conv_pe;
    localparam int unsigned PKT_W = 34;
    localparam logic [3:0]  MY    = 4'b0110;
    localparam logic [3:0]  NB    = 4'b0010;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pkt_drop, busy;
    always #5 clk = ~clk;

    snn_row_conv_pe_if #(.PKT_W(PKT_W)) in_if ();
    snn_row_conv_pe_if #(.PKT_W(PKT_W)) out_if ();

    snn_row_conv_pe #(
        .ADDR_W(4), .K(3), .WGT_W(8), .IFMAP_W(5), .PSUM_W(8), .PKT_W(PKT_W),
        .MY_ADDR(4'b0110), .ADDER_BASE(4'b0001), .ADDER_STRIDE(4),
        .NEIGHBOR_ADDR(4'b0010), .FWD_EN(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_if(in_if.slave), .out_if(out_if.master),
        .pkt_drop(pkt_drop), .busy(busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int drop_cnt = 0;
    int fwd_cnt = 0;
    int tb_w [3];
    int tb_row = 0;
    logic [PKT_W-1:0] sb [$];
    int xfer_cyc [$];
    logic [PKT_W-1:0] exp_pkt;

    always @(posedge clk) cyc <= cyc + 1;

    // A transfer seen valid&ready here completes on the following rising edge.
    always @(negedge clk) begin
        #1;
        if (rst_n) begin
            if (pkt_drop) drop_cnt++;
            if (out_if.valid && out_if.ready) begin
                xfer_cyc.push_back(cyc);
                if (out_if.pkt[25:24] == 2'b00) fwd_cnt++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL out_pkt unexpected: got %h, required no packet", out_if.pkt);
                end else begin
                    exp_pkt = sb.pop_front();
                    if (out_if.pkt !== exp_pkt) begin
                        errors++;
                        $display("FAIL out_pkt: got %h, required %h", out_if.pkt, exp_pkt);
                    end
                end
            end
        end
    end

    task automatic push_row(input logic [4:0] sp);
        for (int j = 0; j < 3; j++) begin
            int s;
            s = 0;
            for (int t = 0; t < 3; t++) if (sp[j+t]) s += tb_w[t];
            if (s > 255) s = 255;
            sb.push_back({MY, 4'(1 + 4*j), 2'b10, 24'(s)});
        end
        if (tb_row < 2) sb.push_back({MY, NB, 2'b00, 24'(sp)});
        tb_row = (tb_row == 2) ? 0 : tb_row + 1;
    endtask

    task automatic send_pkt(input logic [3:0] dst, input logic [1:0] typ,
                            input logic [23:0] pay, output int acc_cyc);
        int n;
        @(negedge clk);
        in_if.valid = 1'b1;
        in_if.pkt   = {4'b1111, dst, typ, pay};
        n = 0;
        #1;
        while (!in_if.ready && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_if.ready) begin
            checks++;
            errors++;
            $display("FAIL in_ready timeout: got 0 after %0d cycles, required 1", n);
        end
        acc_cyc = cyc;
        @(posedge clk);
        #1;
        in_if.valid = 1'b0;
    endtask

    task automatic load_kernel(input int w0, input int w1, input int w2);
        int c;
        send_pkt(MY, 2'b01, {8'(w2), 8'(w1), 8'(w0)}, c);
        tb_w = '{w0, w1, w2};
    endtask

    task automatic send_row(input logic [4:0] sp, output int acc_cyc);
        push_row(sp);
        send_pkt(MY, 2'b00, 24'(sp), acc_cyc);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while ((busy || !in_if.ready || out_if.valid) && n < 300);
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL %s idle timeout: got busy=%0b, required 0", name, busy);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s leftover: got %0d pending packets, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic wait_out_valid(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!out_if.valid && n < 50);
        checks++;
        if (!out_if.valid) begin
            errors++;
            $display("FAIL %s out_valid timeout: got 0, required 1", name);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (in_if.ready !== 1'b0) begin errors++; $display("FAIL reset in_ready: got %b, required 0", in_if.ready); end
        checks++;
        if (out_if.valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b, required 0", out_if.valid); end
        checks++;
        if (out_if.pkt !== '0) begin errors++; $display("FAIL reset out_pkt: got %h, required 0", out_if.pkt); end
        checks++;
        if (pkt_drop !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL reset drop/busy: got %b/%b, required 0/0", pkt_drop, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (in_if.ready !== 1'b1) begin errors++; $display("FAIL post-reset in_ready: got %b, required 1", in_if.ready); end
        out_if.ready = 1'b1;
    endtask

    task automatic test_basic();
        int a;
        load_kernel(3, 5, 7);
        xfer_cyc.delete();
        send_row(5'b10101, a);
        wait_idle("basic");
        checks++;
        if (xfer_cyc.size() != 4) begin
            errors++; $display("FAIL basic transfers: got %0d, required 4", xfer_cyc.size());
        end else begin
            checks++;
            if (xfer_cyc[0] - a != 4) begin errors++; $display("FAIL latency: got %0d, required 4", xfer_cyc[0] - a); end
            checks++;
            if (xfer_cyc[1] - xfer_cyc[0] != 4 || xfer_cyc[2] - xfer_cyc[1] != 4) begin
                errors++; $display("FAIL column spacing: got %0d/%0d, required 4/4",
                                   xfer_cyc[1] - xfer_cyc[0], xfer_cyc[2] - xfer_cyc[1]);
            end
        end
    endtask

    task automatic test_saturate();
        int a;
        load_kernel(200, 200, 200);
        send_row(5'b11111, a);
        wait_idle("saturate");
    endtask

    task automatic test_forward();
        int a, f0;
        f0 = fwd_cnt;
        send_row(5'b00111, a);
        wait_idle("fwd_row2");
        checks++;
        if (fwd_cnt != f0) begin errors++; $display("FAIL row2 forwarded: got %0d fwd, required %0d", fwd_cnt, f0); end
        send_row(5'b11000, a);
        wait_idle("fwd_row3");
        checks++;
        if (fwd_cnt != f0 + 1) begin errors++; $display("FAIL row3 forward: got %0d fwd, required %0d", fwd_cnt, f0 + 1); end
    endtask

    task automatic test_backpressure();
        int a;
        logic [PKT_W-1:0] held;
        load_kernel(3, 5, 7);
        @(negedge clk);
        out_if.ready = 1'b0;
        send_row(5'b01110, a);
        wait_out_valid("backpressure");
        held = out_if.pkt;
        for (int n = 0; n < 7; n++) begin
            @(negedge clk);
            #1;
            checks++;
            if (out_if.valid !== 1'b1 || out_if.pkt !== held || in_if.ready !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL hold cycle %0d: got v=%b pkt=%h rdy=%b, required v=1 pkt=%h rdy=0",
                         n, out_if.valid, out_if.pkt, in_if.ready, held);
            end
        end
        @(negedge clk);
        out_if.ready = 1'b1;
        wait_idle("backpressure");
    endtask

    task automatic test_drop();
        int c, d0;
        d0 = drop_cnt;
        send_pkt(4'b1010, 2'b01, 24'hFFFFFF, c);
        @(negedge clk);
        #2;
        checks++;
        if (drop_cnt != d0 + 1 || busy !== 1'b0) begin
            errors++; $display("FAIL drop dst: got %0d drops busy=%b, required %0d busy=0", drop_cnt - d0, busy, 1);
        end
        send_pkt(MY, 2'b11, 24'hFFFFFF, c);
        @(negedge clk);
        #2;
        checks++;
        if (drop_cnt != d0 + 2) begin errors++; $display("FAIL drop type11: got %0d drops, required 2", drop_cnt - d0); end
        send_pkt(MY, 2'b10, 24'hFFFFFF, c);
        @(negedge clk);
        #2;
        checks++;
        if (drop_cnt != d0 + 3) begin errors++; $display("FAIL drop type10: got %0d drops, required 3", drop_cnt - d0); end
        send_row(5'b10101, c);
        wait_idle("drop_followup");
    endtask

    task automatic reset_pulse(input string name);
        rst_n = 1'b0;
        sb.delete();
        tb_w = '{0, 0, 0};
        tb_row = 0;
        #1;
        checks++;
        if (out_if.valid !== 1'b0 || busy !== 1'b0 || in_if.ready !== 1'b0) begin
            errors++; $display("FAIL %s async reset: got v=%b busy=%b rdy=%b, required 0/0/0",
                               name, out_if.valid, busy, in_if.ready);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (in_if.ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL %s release: got rdy=%b busy=%b, required 1/0", name, in_if.ready, busy);
        end
    endtask

    task automatic test_reset_mid();
        int a, n;
        out_if.ready = 1'b1;
        xfer_cyc.delete();
        send_row(5'b11111, a);
        n = 0;
        while (xfer_cyc.size() < 1 && n < 50) begin @(negedge clk); #2; n++; end
        checks++;
        if (xfer_cyc.size() < 1) begin errors++; $display("FAIL mid-compute column0: got 0 transfers, required 1"); end
        @(negedge clk);
        @(negedge clk);
        reset_pulse("mid_compute");
        send_row(5'b11111, a);
        wait_idle("zero_weights_a");
        load_kernel(3, 5, 7);
        @(negedge clk);
        out_if.ready = 1'b0;
        send_row(5'b10101, a);
        wait_out_valid("mid_emit");
        @(negedge clk);
        reset_pulse("mid_emit");
        out_if.ready = 1'b1;
        send_row(5'b11111, a);
        wait_idle("zero_weights_b");
    endtask

    initial begin
        in_if.valid  = 1'b0;
        in_if.pkt    = '0;
        out_if.ready = 1'b0;
        test_reset();
        test_basic();
        test_saturate();
        test_forward();
        test_backpressure();
        test_drop();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
